stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
- Sequencer for the 16-entry x 11-bit hardware return-address stack and the program counter load path.
- Handles CALL, RETURN/RETLW, RETFIE and interrupt entry from the decoder.
- Generates stack push/pop strobes, the PC load value and the second-cycle pipeline flush.
- Tracks stack depth and raises sticky overflow/underflow flags, plus an optional stack-fault reset request.

Parameters:
- AW, 11, address width; sets the width of the PC and of each stack entry.
- DEPTH, 16, number of stack entries.
- INT_VECTOR, 11'h004, PC loaded on interrupt entry.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- call_req  in  1  decoded CALL/CALLW, valid for one cycle
- call_target  in  AW  CALL destination address
- ret_req  in  1  decoded RETURN/RETLW
- retfie_req  in  1  decoded RETFIE
- int_req  in  1  pending enabled interrupt
- gie  in  1  global interrupt enable, from INTCON
- pc_cur  in  AW  address of the next sequential instruction
- stack_top  in  AW  stack output; top entry
- stvren  in  1  stack fault reset enable, from config
- stkflag_clr  in  1  software clear of stkovf and stkunf
- push  out  1  stack push strobe
- pop  out  1  stack pop strobe
- stack_data  out  AW  value to push
- pc_load  out  1  PC load strobe
- pc_load_val  out  AW  PC load value
- flush  out  1  squash the fetched instruction
- busy  out  1  controller in its second cycle; decoder holds requests
- gie_clr  out  1  clear GIE pulse
- gie_set  out  1  set GIE pulse
- depth  out  5  valid entries, 0..16
- stkovf  out  1  sticky overflow flag
- stkunf  out  1  sticky underflow flag
- stack_reset_req  out  1  one-cycle fault reset request

Behaviour:
- States:
  - IDLE accepts requests.
  - FLUSH lasts exactly one cycle after any accepted operation, then returns to IDLE.
  - busy = flush = (state == FLUSH), both registered.
- Acceptance: only in IDLE. Requests presented during FLUSH are ignored.
- Priority in IDLE: int_req&gie > call_req > retfie_req > ret_req. Only one operation is accepted per cycle.
- Output timing:
  - push, pop, stack_data, pc_load, pc_load_val, gie_clr and gie_set are combinational, asserted in the accepting IDLE cycle only.
  - The stack therefore updates on the same rising edge.
  - When no operation is accepted, all strobes are 0, stack_data = 0 and pc_load_val = 0.
- Interrupt entry:
  - push=1, stack_data=pc_cur.
  - pc_load=1, pc_load_val=INT_VECTOR.
  - gie_clr=1.
- CALL:
  - push=1, stack_data=pc_cur.
  - pc_load=1, pc_load_val=call_target.
- RETURN:
  - pop=1, pc_load=1, pc_load_val=stack_top.
- RETFIE: same as RETURN, plus gie_set=1.
- Depth counter:
  - Push increments depth, saturating at DEPTH.
  - Pop decrements depth.
- Overflow (push accepted with depth==DEPTH):
  - push is still issued; the stack wraps and overwrites the oldest entry.
  - depth stays at 16.
  - stkovf is set next cycle.
- Underflow (pop accepted with depth==0):
  - pop is suppressed (0).
  - pc_load=1 with pc_load_val=0.
  - depth stays at 0.
  - stkunf is set next cycle.
- Fault reset: stack_reset_req is a registered single-cycle pulse, asserted the cycle after any overflow or underflow event when stvren=1. It is never asserted when stvren=0.
- Flag clear: stkflag_clr clears both flags next cycle. If a set and a clear occur in the same cycle, the set wins.
- Reset, including mid-FLUSH:
  - Next edge: state=IDLE, depth=0, stkovf=0, stkunf=0, stack_reset_req=0, busy=0, flush=0.
  - Combinational strobes are forced to 0 while reset=1.
  - The stack block is reset on the same signal.
- Width rules:
  - depth is 5 bits, with no wrap beyond 16.
  - All addresses are AW bits with no arithmetic; pc_cur is supplied already incremented.

Test Plan:
- CALL, then RETURN: pc_cur=0x010, call_target=0x200. Required: push=1, stack_data=0x010, pc_load_val=0x200 and depth 0->1; next cycle flush=1. Then ret_req with stack_top=0x010: pop=1, pc_load_val=0x010, depth=0.
- Interrupt entry, then RETFIE: int_req=1, gie=1 and call_req=1 together, pc_cur=0x055. Required: interrupt wins, stack_data=0x055, pc_load_val=0x004, gie_clr=1, no call. Then RETFIE: gie_set=1, pc_load_val=0x055.
- Overflow with stvren=1: issue 17 CALLs. Required: depth holds at 16; on the 17th, push=1, stkovf=1 the next cycle and stack_reset_req pulses for exactly 1 cycle.
- Underflow and flag clear: RETURN at depth=0 with stvren=0. Required: pop=0, pc_load_val=0x000, stkunf=1, stack_reset_req never asserted. Then stkflag_clr=1: stkunf=0. Then stkflag_clr coinciding with a new underflow: stkunf remains 1.
- Requests during FLUSH: call_req held for 2 cycles. Required: exactly one push, and depth increments by 1 only.
- Reset in FLUSH: reset asserted in the FLUSH cycle at depth=3. Required: next cycle busy=0, depth=0, flags=0, and no strobes while reset is high.

Source files
------------

// File: rtl/stack_ctrl.sv
// Return-address stack sequencer: turns decoded CALL/RETURN/RETFIE/interrupt
// requests into stack push/pop strobes, PC loads and a one-cycle flush.
module stack_ctrl #(
  parameter int AW = 11,
  parameter int DEPTH = 16,
  parameter logic [AW-1:0] INT_VECTOR = 'h004
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          call_req,
  input  logic [AW-1:0] call_target,
  input  logic          ret_req,
  input  logic          retfie_req,
  input  logic          int_req,
  input  logic          gie,
  input  logic [AW-1:0] pc_cur,
  input  logic [AW-1:0] stack_top,
  input  logic          stvren,
  input  logic          stkflag_clr,
  output logic          push,
  output logic          pop,
  output logic [AW-1:0] stack_data,
  output logic          pc_load,
  output logic [AW-1:0] pc_load_val,
  output logic          flush,
  output logic          busy,
  output logic          gie_clr,
  output logic          gie_set,
  output logic [4:0]    depth,
  output logic          stkovf,
  output logic          stkunf,
  output logic          stack_reset_req
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [4:0] DEPTH_MAX = 5'(DEPTH);

  state_t state;
  state_t state_next;

  logic take_int;
  logic take_call;
  logic take_retfie;
  logic take_ret;
  logic accepted;
  logic do_push;
  logic do_pop;
  logic empty;
  logic full;
  logic ovf_event;
  logic unf_event;

  // Fixed-priority acceptance; reset masks every request so no strobe escapes.
  always_comb begin
    take_int    = 1'b0;
    take_call   = 1'b0;
    take_retfie = 1'b0;
    take_ret    = 1'b0;
    if (!reset && state == IDLE) begin
      if (int_req && gie)  take_int    = 1'b1;
      else if (call_req)   take_call   = 1'b1;
      else if (retfie_req) take_retfie = 1'b1;
      else if (ret_req)    take_ret    = 1'b1;
    end
  end

  assign accepted  = take_int | take_call | take_retfie | take_ret;
  assign do_push   = take_int | take_call;
  assign do_pop    = take_retfie | take_ret;
  assign empty     = (depth == 5'd0);
  assign full      = (depth == DEPTH_MAX);
  assign ovf_event = do_push & full;
  assign unf_event = do_pop & empty;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accepted) state_next = FLUSH;
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A pop at depth 0 is swallowed and the PC goes to address zero instead.
  always_comb begin
    push        = 1'b0;
    pop         = 1'b0;
    stack_data  = '0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    gie_clr     = 1'b0;
    gie_set     = 1'b0;
    if (take_int) begin
      push        = 1'b1;
      stack_data  = pc_cur;
      pc_load     = 1'b1;
      pc_load_val = INT_VECTOR;
      gie_clr     = 1'b1;
    end else if (take_call) begin
      push        = 1'b1;
      stack_data  = pc_cur;
      pc_load     = 1'b1;
      pc_load_val = call_target;
    end else if (do_pop) begin
      pop         = !empty;
      pc_load     = 1'b1;
      pc_load_val = empty ? '0 : stack_top;
      gie_set     = take_retfie;
    end
  end

  assign busy  = (state == FLUSH);
  assign flush = (state == FLUSH);

  always_ff @(posedge clk) begin
    if (reset) begin
      depth <= 5'd0;
    end else if (do_push && !full) begin
      depth <= depth + 5'd1;
    end else if (do_pop && !empty) begin
      depth <= depth - 5'd1;
    end
  end

  // Flags are sticky; a fresh event outranks a simultaneous software clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      stkovf          <= 1'b0;
      stkunf          <= 1'b0;
      stack_reset_req <= 1'b0;
    end else begin
      if (ovf_event)        stkovf <= 1'b1;
      else if (stkflag_clr) stkovf <= 1'b0;
      if (unf_event)        stkunf <= 1'b1;
      else if (stkflag_clr) stkunf <= 1'b0;
      stack_reset_req <= (ovf_event | unf_event) & stvren;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: a queue-based model of the return stack and flags is
// compared against the DUT every cycle, under directed and random requests.
module tb_stack_ctrl;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          call_req;
  logic [AW-1:0] call_target;
  logic          ret_req;
  logic          retfie_req;
  logic          int_req;
  logic          gie;
  logic [AW-1:0] pc_cur;
  logic [AW-1:0] stack_top;
  logic          stvren;
  logic          stkflag_clr;
  logic          push;
  logic          pop;
  logic [AW-1:0] stack_data;
  logic          pc_load;
  logic [AW-1:0] pc_load_val;
  logic          flush;
  logic          busy;
  logic          gie_clr;
  logic          gie_set;
  logic [4:0]    depth;
  logic          stkovf;
  logic          stkunf;
  logic          stack_reset_req;

  always #5 clk = ~clk;

  stack_ctrl #(.AW(AW), .DEPTH(16), .INT_VECTOR(11'h004)) dut (
    .clk(clk), .reset(reset), .call_req(call_req), .call_target(call_target),
    .ret_req(ret_req), .retfie_req(retfie_req), .int_req(int_req), .gie(gie),
    .pc_cur(pc_cur), .stack_top(stack_top), .stvren(stvren),
    .stkflag_clr(stkflag_clr), .push(push), .pop(pop), .stack_data(stack_data),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .flush(flush), .busy(busy),
    .gie_clr(gie_clr), .gie_set(gie_set), .depth(depth), .stkovf(stkovf),
    .stkunf(stkunf), .stack_reset_req(stack_reset_req)
  );

  int nVectors = 0;
  int nMiscompares = 0;

  // Model: the stack is a queue holding at most 16 return addresses.
  logic [AW-1:0] mStack[$];
  int  mDepth;
  bit  mBusy, mOvf, mUnf, mSrr;
  bit  pTake, pPush, pPop;

  logic sPush, sPop, sLoad, sGieClr, sGieSet, sBusy, sOvf, sUnf, sSrr;
  logic [AW-1:0] sData, sVal;
  logic [4:0] sDepth;

  task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    bit isInt, isRetfie, ePop;
    logic [AW-1:0] eVal, eData;
    pTake = !reset && !mBusy && ((int_req && gie) || call_req || retfie_req || ret_req);
    isInt = pTake && int_req && gie;
    pPush = pTake && (isInt || call_req);
    pPop  = pTake && !pPush;
    isRetfie = pPop && retfie_req;
    ePop  = pPop && (mDepth > 0);
    eData = pPush ? pc_cur : '0;
    if (isInt)      eVal = 11'h004;
    else if (pPush) eVal = call_target;
    else if (ePop)  eVal = mStack[$];
    else            eVal = '0;
    compare("push", 16'(push), 16'(pPush));
    compare("pop", 16'(pop), 16'(ePop));
    compare("stack_data", 16'(stack_data), 16'(eData));
    compare("pc_load", 16'(pc_load), 16'(pTake));
    compare("pc_load_val", 16'(pc_load_val), 16'(eVal));
    compare("flush", 16'(flush), 16'(mBusy));
    compare("busy", 16'(busy), 16'(mBusy));
    compare("gie_clr", 16'(gie_clr), 16'(isInt));
    compare("gie_set", 16'(gie_set), 16'(isRetfie));
    compare("depth", 16'(depth), 16'(mDepth));
    compare("stkovf", 16'(stkovf), 16'(mOvf));
    compare("stkunf", 16'(stkunf), 16'(mUnf));
    compare("stack_reset_req", 16'(stack_reset_req), 16'(mSrr));
    sPush = push; sPop = pop; sLoad = pc_load; sGieClr = gie_clr; sGieSet = gie_set;
    sBusy = busy; sOvf = stkovf; sUnf = stkunf; sSrr = stack_reset_req;
    sData = stack_data; sVal = pc_load_val; sDepth = depth;
  endtask

  task automatic updateModel();
    bit ovfEvt, unfEvt;
    if (reset) begin
      mStack.delete();
      mDepth = 0; mBusy = 0; mOvf = 0; mUnf = 0; mSrr = 0;
    end else begin
      ovfEvt = pPush && mDepth == 16;
      unfEvt = pPop && mDepth == 0;
      if (pPush) begin
        mStack.push_back(pc_cur);
        if (mStack.size() > 16) void'(mStack.pop_front());
        if (mDepth < 16) mDepth++;
      end
      if (pPop && mDepth > 0) begin
        void'(mStack.pop_back());
        mDepth--;
      end
      mOvf  = ovfEvt ? 1'b1 : (stkflag_clr ? 1'b0 : mOvf);
      mUnf  = unfEvt ? 1'b1 : (stkflag_clr ? 1'b0 : mUnf);
      mSrr  = (ovfEvt || unfEvt) && stvren;
      mBusy = pTake;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit ci, input logic [AW-1:0] ct,
                               input bit ri, input bit rfi, input bit ii, input bit g,
                               input logic [AW-1:0] pc, input bit sv, input bit clr);
    @(negedge clk);
    reset = rst; call_req = ci; call_target = ct; ret_req = ri; retfie_req = rfi;
    int_req = ii; gie = g; pc_cur = pc; stvren = sv; stkflag_clr = clr;
    stack_top = (mStack.size() > 0) ? mStack[$] : '0;
    #1;
    checkOutput();
    @(posedge clk);
    updateModel();
  endtask

  task automatic idle(input bit sv, input bit clr);
    applyStimulus(0, 0, '0, 0, 0, 0, 0, 11'h7ff, sv, clr);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, '0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    reset = 1; call_req = 0; call_target = '0; ret_req = 0; retfie_req = 0;
    int_req = 0; gie = 0; pc_cur = '0; stvren = 0; stkflag_clr = 0; stack_top = '0;
    repeat (2) @(posedge clk);
    mStack.delete();
    mDepth = 0; mBusy = 0; mOvf = 0; mUnf = 0; mSrr = 0;

    // Reset state, then CALL 0x200 from 0x010 followed by RETURN
    idle(0, 0);
    compare("lit_reset_depth", 16'(sDepth), 16'd0);
    compare("lit_reset_busy", 16'(sBusy), 16'd0);
    applyStimulus(0, 1, 11'h200, 0, 0, 0, 0, 11'h010, 0, 0);
    compare("lit_call_push", 16'(sPush), 16'd1);
    compare("lit_call_data", 16'(sData), 16'h010);
    compare("lit_call_val", 16'(sVal), 16'h200);
    idle(0, 0);
    compare("lit_call_flush", 16'(sBusy), 16'd1);
    compare("lit_call_depth", 16'(sDepth), 16'd1);
    applyStimulus(0, 0, '0, 1, 0, 0, 0, 11'h201, 0, 0);
    compare("lit_ret_pop", 16'(sPop), 16'd1);
    compare("lit_ret_val", 16'(sVal), 16'h010);
    idle(0, 0);
    compare("lit_ret_depth", 16'(sDepth), 16'd0);

    // Interrupt beats a simultaneous CALL, then RETFIE
    applyStimulus(0, 1, 11'h300, 0, 0, 1, 1, 11'h055, 0, 0);
    compare("lit_int_data", 16'(sData), 16'h055);
    compare("lit_int_val", 16'(sVal), 16'h004);
    compare("lit_int_gieclr", 16'(sGieClr), 16'd1);
    idle(0, 0);
    applyStimulus(0, 0, '0, 0, 1, 0, 0, 11'h005, 0, 0);
    compare("lit_retfie_gieset", 16'(sGieSet), 16'd1);
    compare("lit_retfie_val", 16'(sVal), 16'h055);
    idle(0, 0);

    // Overflow with stvren=1 after 17 CALLs
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(0, 1, 11'h100 + 11'(i), 0, 0, 0, 0, 11'h020 + 11'(i), 1, 0);
      if (i == 16) begin
        compare("lit_ovf_push", 16'(sPush), 16'd1);
        compare("lit_ovf_depth_before", 16'(sDepth), 16'd16);
      end
      idle(1, 0);
    end
    compare("lit_ovf_flag", 16'(sOvf), 16'd1);
    compare("lit_ovf_srr", 16'(sSrr), 16'd1);
    idle(1, 0);
    compare("lit_ovf_srr_pulse", 16'(sSrr), 16'd0);
    compare("lit_ovf_depth_after", 16'(sDepth), 16'd16);

    // Underflow with stvren=0, flag clear, and clear colliding with a new underflow
    doReset();
    applyStimulus(0, 0, '0, 1, 0, 0, 0, 11'h033, 0, 0);
    compare("lit_unf_pop", 16'(sPop), 16'd0);
    compare("lit_unf_load", 16'(sLoad), 16'd1);
    compare("lit_unf_val", 16'(sVal), 16'h000);
    idle(0, 0);
    compare("lit_unf_flag", 16'(sUnf), 16'd1);
    compare("lit_unf_srr", 16'(sSrr), 16'd0);
    idle(0, 1);
    idle(0, 0);
    compare("lit_unf_cleared", 16'(sUnf), 16'd0);
    applyStimulus(0, 0, '0, 1, 0, 0, 0, 11'h034, 0, 1);
    idle(0, 0);
    compare("lit_unf_set_wins", 16'(sUnf), 16'd1);

    // CALL held across the FLUSH cycle is taken once
    doReset();
    applyStimulus(0, 1, 11'h444, 0, 0, 0, 0, 11'h011, 0, 0);
    applyStimulus(0, 1, 11'h444, 0, 0, 0, 0, 11'h011, 0, 0);
    compare("lit_hold_nopush", 16'(sPush), 16'd0);
    idle(0, 0);
    compare("lit_hold_depth", 16'(sDepth), 16'd1);

    // Reset during FLUSH at depth 3
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 11'h600, 0, 0, 0, 0, 11'h070 + 11'(i), 0, 0);
      if (i < 2) idle(0, 0);
    end
    applyStimulus(1, 1, 11'h600, 1, 0, 1, 1, 11'h099, 0, 0);
    compare("lit_rstflush_depth", 16'(sDepth), 16'd3);
    compare("lit_rstflush_push", 16'(sPush), 16'd0);
    idle(0, 0);
    compare("lit_rstflush_busy", 16'(sBusy), 16'd0);
    compare("lit_rstflush_depth0", 16'(sDepth), 16'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(99) < 2),
                    ($urandom_range(99) < 35), 11'($urandom),
                    ($urandom_range(99) < 30), ($urandom_range(99) < 15),
                    ($urandom_range(99) < 15), 1'($urandom),
                    11'($urandom), 1'($urandom),
                    ($urandom_range(99) < 10));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end
endmodule
